rr_arbiter4: RTL and testbench

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4_if.sv | 20 ++
 rtl/rr_arbiter4.sv | 124 ++++++++++++
 tb/tb_rr_arbiter4.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle of the 4-way round-robin arbiter.
// The requester side (master) drives en/req; the arbiter (slave) drives the grant.
interface rr_arbiter4_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       expired;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, expired
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, expired
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// All outputs come straight from flops; a grant lands one edge after its request.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       expired_q, expired_d;
  logic [2:0] win;
  logic       take;
  logic       drop;

  // Returns {found, index} of the first asserted request after `last`, wrapping to `last`.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!res[2] && req[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state, hold counter and grant decode.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    take      = 1'b0;
    drop      = 1'b0;
    win       = rr_pick(bus.req, last_q);

    case (state_q)
      IDLE: begin
        if (bus.en && win[2]) begin
          take = 1'b1;
        end else begin
          take = 1'b0;
        end
      end
      GRANT: begin
        // A release wins over a simultaneous expiry, so expired is only raised while req is held.
        if (!bus.req[idx_q]) begin
          if (bus.en && win[2]) begin
            take = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (cnt_q >= MAX_HOLD_C) begin
          expired_d = 1'b1;
          if (bus.en && win[2]) begin
            take = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else begin
          cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end
      end
      default: begin
        drop = 1'b1;
      end
    endcase

    if (take) begin
      state_d = GRANT;
      idx_d   = win[1:0];
      last_d  = win[1:0];
      cnt_d   = 4'd1;
    end else if (drop) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = 4'd0;
    end else begin
      state_d = state_d;
    end

    gnt_d = (state_d == GRANT) ? (4'b0001 << idx_d) : 4'b0000;
  end

  // State and output registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      idx_q     <= 2'd0;
      cnt_q     <= 4'd0;
      gnt_q     <= 4'b0000;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      expired_q <= expired_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.expired   = expired_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance with MAX_HOLD=4, one with MAX_HOLD=1.
module tb_rr_arbiter4;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  rr_arbiter4_if bus_a();
  rr_arbiter4_if bus_b();

  rr_arbiter4 #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
  rr_arbiter4 #(.MAX_HOLD(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

  always #5 clk = ~clk;

  logic [3:0] g29 [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                          4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
  logic [1:0] i29 [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
  logic [3:0] gb  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] ib  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic sel_b, input logic [3:0] g,
                     input logic [1:0] i, input logic v, input logic e);
    logic [7:0] obs;
    logic [7:0] expv;
    if (sel_b) begin
      obs = {bus_b.gnt, bus_b.gnt_idx, bus_b.gnt_valid, bus_b.expired};
    end else begin
      obs = {bus_a.gnt, bus_a.gnt_idx, bus_a.gnt_valid, bus_a.expired};
    end
    expv = {g, i, v, e};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed gnt=%b idx=%0d valid=%b expired=%b, expected gnt=%b idx=%0d valid=%b expired=%b",
             tag, obs[7:4], obs[3:2], obs[1], obs[0], g, i, v, e);
    end
  endtask

  initial begin
    rst_a = 1'b1; bus_a.en = 1'b0; bus_a.req = 4'b0000;
    rst_b = 1'b1; bus_b.en = 1'b0; bus_b.req = 4'b0000;

    step();
    chk("reset", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    rst_a = 1'b0; bus_a.en = 1'b1; bus_a.req = 4'b1010;
    step();
    chk("first_grant", 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);

    bus_a.req = 4'b1000;
    step();
    chk("handoff_no_gap", 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);

    bus_a.req = 4'b0000;
    step();
    chk("release_to_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    rst_a = 1'b1;
    step();
    chk("reset2", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_a = 1'b0; bus_a.req = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("expiry_rotate", 1'b0, g29[k], i29[k], 1'b1, (k == 4) || (k == 8));
    end

    rst_a = 1'b1; bus_a.req = 4'b0000;
    step();
    chk("reset3", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_a = 1'b0; bus_a.req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("regrant_self", 1'b0, 4'b0100, 2'd2, 1'b1, (k == 4) || (k == 8));
    end

    bus_a.en = 1'b0; bus_a.req = 4'b1111;
    step();
    chk("en_low_hold1", 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    chk("en_low_hold2", 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    chk("en_low_expire", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk("en_low_idle1", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk("en_low_idle2", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    bus_a.en = 1'b1;
    step();
    chk("en_high_grant", 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);

    rst_a = 1'b1;
    step();
    chk("reset_mid_grant", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_a = 1'b0;
    step();
    chk("post_reset_grant", 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_to_max", 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    end

    bus_a.req = 4'b1110;
    step();
    chk("release_at_max", 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);

    bus_a.en = 1'b0; bus_a.req = 4'b1100;
    step();
    chk("release_en_low", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    bus_a.en = 1'b1;
    step();
    chk("rearb_after_idle", 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);

    step();
    chk("reset_b", 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_b = 1'b0; bus_b.en = 1'b1; bus_b.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold1_rotate", 1'b1, gb[k], ib[k], 1'b1, k > 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
